// File: rtl/gray_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gray_chk_pkg
// Description : Shared types, error codes and helpers for the Gray checker.
// Revision    : 1.0 - initial release
// ============================================================================
package gray_chk_pkg;

    localparam int GRAY_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_MULTI = 2'b01;
    localparam logic [1:0] ERR_SKIP  = 2'b10;
    localparam logic [1:0] ERR_OVF   = 2'b11;

    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [1:0] popcount3(input logic [GRAY_W-1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray2bin.sv
`default_nettype none
// ============================================================================
// Module      : gray2bin
// Description : Combinational 3-bit Gray-to-binary decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module gray2bin
    import gray_chk_pkg::*;
(
    input  logic [GRAY_W-1:0] i_gray,
    output logic [GRAY_W-1:0] o_bin
);

    always_comb begin
        o_bin[2] = i_gray[2];
        o_bin[1] = o_bin[2] ^ i_gray[1];
        o_bin[0] = o_bin[1] ^ i_gray[0];
    end

endmodule
`default_nettype wire

// File: rtl/gray_checker.sv
`default_nettype none
// ============================================================================
// Module      : gray_checker
// Description : Decodes and checks a 3-bit Gray counter stream, counts wraps.
//               GRAY_CHK_STICKY_ERR_EN: latch first error until Reset.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_checker
    import gray_chk_pkg::*;
#(
    parameter int CNT_W = 8
)(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              En,
    input  logic [2:0]        Gray,
    input  logic              Overflow,
    output logic [2:0]        Bin,
    output logic              Locked,
    output logic [CNT_W-1:0]  WrapCnt,
    output logic              Err,
    output logic [1:0]        ErrCode
);

    state_t             r_state, w_state_nxt;
    logic [2:0]         r_bin, w_bin_nxt;
    logic               r_locked, w_locked_nxt;
    logic [CNT_W-1:0]   r_wrap, w_wrap_nxt;
    logic               r_err, w_err_nxt;
    logic [1:0]         r_code, w_code_nxt;
    logic               r_ovf_prev;

    logic [2:0]         w_new_bin;
    logic [1:0]         w_dist;
    logic               w_succ;
    logic               w_is_wrap;
    logic               w_ovf_rise;
    logic [1:0]         w_chk_code;

    gray2bin u_dec (
        .i_gray (Gray),
        .o_bin  (w_new_bin)
    );

    // The reference is held in binary; its Gray form is rebuilt for the distance check.
    assign w_dist     = popcount3(Gray ^ bin2gray(r_bin));
    assign w_succ     = (w_new_bin == r_bin + 3'd1);
    assign w_is_wrap  = (w_dist == 2'd1) && (r_bin == 3'd7) && (w_new_bin == 3'd0);
    assign w_ovf_rise = Overflow & ~r_ovf_prev;

    always_comb begin
        w_chk_code = ERR_NONE;
        if (w_dist > 2'd1)
            w_chk_code = ERR_MULTI;
        else if ((w_dist == 2'd1) && !w_succ)
            w_chk_code = ERR_SKIP;
        else if (w_ovf_rise != w_is_wrap)
            w_chk_code = ERR_OVF;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_bin_nxt    = r_bin;
        w_locked_nxt = r_locked;
        w_wrap_nxt   = r_wrap;
`ifdef GRAY_CHK_STICKY_ERR_EN
        w_err_nxt    = r_err;
        w_code_nxt   = r_code;
`else
        w_err_nxt    = 1'b0;
        w_code_nxt   = ERR_NONE;
`endif
        case (r_state)
            ST_IDLE: begin
                if (En) begin
                    w_bin_nxt    = w_new_bin;
                    w_locked_nxt = 1'b1;
                    w_state_nxt  = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (En) begin
                    if (w_chk_code == ERR_NONE) begin
                        w_bin_nxt = w_new_bin;
                        if (w_is_wrap && (r_wrap != {CNT_W{1'b1}}))
                            w_wrap_nxt = r_wrap + 1'b1;
                    end else begin
                        w_err_nxt  = 1'b1;
                        w_code_nxt = w_chk_code;
`ifdef GRAY_CHK_STICKY_ERR_EN
                        w_locked_nxt = 1'b0;
                        w_state_nxt  = ST_ERR;
`else
                        // Resynchronise on the offending sample so one glitch reports once.
                        w_bin_nxt = w_new_bin;
`endif
                    end
                end
            end
            ST_ERR: begin
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_bin      <= 3'd0;
            r_locked   <= 1'b0;
            r_wrap     <= '0;
            r_err      <= 1'b0;
            r_code     <= ERR_NONE;
            r_ovf_prev <= 1'b0;
        end else begin
            r_bin      <= w_bin_nxt;
            r_locked   <= w_locked_nxt;
            r_wrap     <= w_wrap_nxt;
            r_err      <= w_err_nxt;
            r_code     <= w_code_nxt;
            r_ovf_prev <= Overflow;
        end
    end

    assign Bin     = r_bin;
    assign Locked  = r_locked;
    assign WrapCnt = r_wrap;
    assign Err     = r_err;
    assign ErrCode = r_code;

endmodule
`default_nettype wire
